// File: rtl/exc_ctrl.sv
// MEM-stage exception detector/arbiter.
// Merges the per-instruction exception flags with pending interrupts, reports
// one exception to CP0 in the same cycle, then runs a fixed-length pipeline
// flush with a registered redirect PC (exception vector, or EPC for ERET).
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        inst_valid_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [7:0]  exc_flags_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam logic [4:0]  ADDR_STATUS = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE  = 5'd13;
    localparam logic [4:0]  ADDR_EPC    = 5'd14;

    localparam logic [31:0] CODE_NONE = 32'h0;
    localparam logic [31:0] CODE_INT  = 32'h1;
    localparam logic [31:0] CODE_ADEL = 32'h4;
    localparam logic [31:0] CODE_ADES = 32'h5;
    localparam logic [31:0] CODE_SYS  = 32'h8;
    localparam logic [31:0] CODE_BP   = 32'h9;
    localparam logic [31:0] CODE_RI   = 32'ha;
    localparam logic [31:0] CODE_OV   = 32'hc;
    localparam logic [31:0] CODE_ERET = 32'he;

    localparam logic [3:0]  CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        flush_reg, flush_next;
    logic [31:0] new_pc_reg, new_pc_next;

    logic [31:0] status_eff;
    logic [31:0] cause_eff;
    logic [31:0] epc_eff;
    logic        int_pending;
    logic        detect_en;
    logic [31:0] exc_code;
    logic [31:0] bad_addr;

    // Bypass a CP0 write that is in WB this cycle; only Cause.IP[1:0] (the
    // software interrupt bits) are writable, the rest of Cause is hardware state.
    always_comb begin
        status_eff = cp0_status_i;
        cause_eff  = cp0_cause_i;
        epc_eff    = cp0_epc_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_STATUS)
            status_eff = wb_cp0_data_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_CAUSE)
            cause_eff[9:8] = wb_cp0_data_i[9:8];
        if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_EPC)
            epc_eff = wb_cp0_data_i;
    end

    assign int_pending = ((cause_eff[15:8] & status_eff[15:8]) != 8'h0)
                         && status_eff[0] && !status_eff[1];

    // Bubbles, stalls and flushed slots never commit an exception; an
    // interrupt simply waits for the next real instruction.
    assign detect_en = (state_reg == IDLE) && !stall && !rst && inst_valid_i;

    // Fixed-priority exception selection, first match wins.
    always_comb begin
        exc_code = CODE_NONE;
        bad_addr = 32'h0;
        if (detect_en) begin
            if (int_pending) begin
                exc_code = CODE_INT;
            end else if (exc_flags_i[0]) begin
                exc_code = CODE_ADEL;
                bad_addr = pc_i;
            end else if (exc_flags_i[1]) begin
                exc_code = CODE_RI;
            end else if (exc_flags_i[2]) begin
                exc_code = CODE_OV;
            end else if (exc_flags_i[3]) begin
                exc_code = CODE_SYS;
            end else if (exc_flags_i[4]) begin
                exc_code = CODE_BP;
            end else if (exc_flags_i[5]) begin
                exc_code = CODE_ADEL;
                bad_addr = data_addr_i;
            end else if (exc_flags_i[6]) begin
                exc_code = CODE_ADES;
                bad_addr = data_addr_i;
            end else if (exc_flags_i[7]) begin
                exc_code = CODE_ERET;
            end
        end
    end

    // Flush sequencer next-state: load the counter on detection, count down
    // to zero while holding the redirect PC, stall has no effect in FLUSH.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        flush_next  = flush_reg;
        new_pc_next = new_pc_reg;
        case (state_reg)
            IDLE: begin
                flush_next = 1'b0;
                if (exc_code != CODE_NONE) begin
                    state_next  = FLUSH;
                    flush_next  = 1'b1;
                    cnt_next    = CNT_LOAD;
                    new_pc_next = (exc_code == CODE_ERET) ? epc_eff : EXC_VECTOR;
                end
            end
            FLUSH: begin
                if (cnt_reg == 4'd0) begin
                    state_next = IDLE;
                    flush_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                flush_next = 1'b0;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Sequencer registers, cleared immediately by reset even mid-flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            flush_reg  <= 1'b0;
            new_pc_reg <= 32'h0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            flush_reg  <= flush_next;
            new_pc_reg <= new_pc_next;
        end
    end

    assign excepttype_o        = exc_code;
    assign bad_addr_o          = bad_addr;
    assign current_inst_addr_o = pc_i;
    assign is_in_delayslot_o   = is_in_delayslot_i;
    assign flush_o             = flush_reg;
    assign new_pc_o            = new_pc_reg;

    // CP0 register fields that play no part in exception arbitration.
    logic unused_bits;
    assign unused_bits = ^{status_eff[31:16], status_eff[7:2],
                           cause_eff[31:16], cause_eff[7:0],
                           wb_cp0_data_i[31:10], wb_cp0_data_i[7:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: a table of single-cycle arbitration vectors
// plus hand-written sequences for flush timing, ERET bypass, stall and reset.
`timescale 1ns/1ps
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        inst_valid_i;
    logic [31:0] pc_i;
    logic        is_in_delayslot_i;
    logic [7:0]  exc_flags_i;
    logic [31:0] data_addr_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    int checks   = 0;
    int failures = 0;

    exc_ctrl #(.EXC_VECTOR(32'hBFC00380), .FLUSH_CYCLES(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .inst_valid_i        (inst_valid_i),
        .pc_i                (pc_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .exc_flags_i         (exc_flags_i),
        .data_addr_i         (data_addr_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .wb_cp0_we_i         (wb_cp0_we_i),
        .wb_cp0_waddr_i      (wb_cp0_waddr_i),
        .wb_cp0_data_i       (wb_cp0_data_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .bad_addr_o          (bad_addr_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        valid;
        logic        slot;
        logic [31:0] pc;
        logic [7:0]  flags;
        logic [31:0] daddr;
        logic [31:0] status;
        logic [31:0] cause;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] exp_code;
        logic [31:0] exp_bad;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic st, logic v, logic sl, logic [31:0] pc,
                                logic [7:0] fl, logic [31:0] da, logic [31:0] s,
                                logic [31:0] c, logic we, logic [4:0] wa,
                                logic [31:0] wd, logic [31:0] ec, logic [31:0] eb);
        vec_t r;
        r.stall = st; r.valid = v; r.slot = sl; r.pc = pc; r.flags = fl;
        r.daddr = da; r.status = s; r.cause = c; r.we = we; r.waddr = wa;
        r.wdata = wd; r.exp_code = ec; r.exp_bad = eb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic idle_inputs();
        stall = 1'b0; inst_valid_i = 1'b0; pc_i = 32'h0; is_in_delayslot_i = 1'b0;
        exc_flags_i = 8'h0; data_addr_i = 32'h0; cp0_status_i = 32'h0;
        cp0_cause_i = 32'h0; cp0_epc_i = 32'h0; wb_cp0_we_i = 1'b0;
        wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;
    endtask

    task automatic syscall_at(input logic [31:0] pc);
        inst_valid_i = 1'b1; pc_i = pc; exc_flags_i = 8'h08;
    endtask

    // Watchdog: the bench has no open-ended waits, but never let it hang.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // st v sl pc flags daddr status cause we waddr wdata exp_code exp_bad
        vecs[0]  = mk(0,1,0,32'hBFC00100,8'h08,32'h0,32'h0,32'h0,0,5'd0,32'h0,32'h8,32'h0);
        vecs[1]  = mk(0,1,1,32'hBFC00204,8'h40,32'h80000003,32'h0,32'h0,0,5'd0,32'h0,32'h5,32'h80000003);
        vecs[2]  = mk(0,1,0,32'h00001000,8'h02,32'h0,32'h401,32'h400,0,5'd0,32'h0,32'h1,32'h0);
        vecs[3]  = mk(0,1,0,32'h00001000,8'h02,32'h0,32'h403,32'h400,0,5'd0,32'h0,32'ha,32'h0);
        vecs[4]  = mk(0,0,0,32'h00001000,8'h02,32'h0,32'h401,32'h400,0,5'd0,32'h0,32'h0,32'h0);
        vecs[5]  = mk(1,1,0,32'h00002000,8'h04,32'h0,32'h0,32'h0,0,5'd0,32'h0,32'h0,32'h0);
        vecs[6]  = mk(0,1,0,32'h00002000,8'h04,32'h0,32'h0,32'h0,0,5'd0,32'h0,32'hc,32'h0);
        vecs[7]  = mk(0,1,1,32'h00003001,8'hFF,32'h12345678,32'h0,32'h0,0,5'd0,32'h0,32'h4,32'h00003001);
        vecs[8]  = mk(0,1,0,32'h00003000,8'h30,32'h12345678,32'h0,32'h0,0,5'd0,32'h0,32'h9,32'h0);
        vecs[9]  = mk(0,1,0,32'h00003000,8'h20,32'h1234567A,32'h0,32'h0,0,5'd0,32'h0,32'h4,32'h1234567A);
        vecs[10] = mk(0,1,0,32'h00003000,8'hC0,32'h0000000E,32'h0,32'h0,0,5'd0,32'h0,32'h5,32'h0000000E);
        vecs[11] = mk(0,1,0,32'h00003000,8'h80,32'h0000000E,32'h0,32'h0,0,5'd0,32'h0,32'he,32'h0);
        vecs[12] = mk(0,1,0,32'h00004000,8'h00,32'h0,32'h0,32'h400,1,5'd12,32'h401,32'h1,32'h0);
        vecs[13] = mk(0,1,0,32'h00004000,8'h00,32'h0,32'h0000FF01,32'h0,1,5'd13,32'h100,32'h1,32'h0);
        vecs[14] = mk(0,1,0,32'h00004000,8'h00,32'h0,32'h0000FF01,32'h0,1,5'd13,32'h400,32'h0,32'h0);
        vecs[15] = mk(0,1,0,32'h00004000,8'h00,32'h0,32'h400,32'h400,0,5'd0,32'h0,32'h0,32'h0);

        idle_inputs();
        rst = 1'b1;

        // Reset state: a valid syscall must not be reported while in reset.
        @(negedge clk);
        syscall_at(32'hBFC00100);
        #1;
        chk("reset_code", excepttype_o, 32'h0);
        chk("reset_pc_pass", current_inst_addr_o, 32'hBFC00100);
        chk("reset_flush", {31'h0, flush_o}, 32'h0);
        chk("reset_newpc", new_pc_o, 32'h0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;

        // Table: combinational arbitration; valid dropped before the next edge.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            stall = vecs[i].stall; inst_valid_i = vecs[i].valid; is_in_delayslot_i = vecs[i].slot;
            pc_i = vecs[i].pc; exc_flags_i = vecs[i].flags; data_addr_i = vecs[i].daddr;
            cp0_status_i = vecs[i].status; cp0_cause_i = vecs[i].cause;
            wb_cp0_we_i = vecs[i].we; wb_cp0_waddr_i = vecs[i].waddr; wb_cp0_data_i = vecs[i].wdata;
            #1;
            chk($sformatf("v%0d_code", i), excepttype_o, vecs[i].exp_code);
            chk($sformatf("v%0d_bad", i), bad_addr_o, vecs[i].exp_bad);
            chk($sformatf("v%0d_pc", i), current_inst_addr_o, vecs[i].pc);
            chk($sformatf("v%0d_slot", i), {31'h0, is_in_delayslot_o}, {31'h0, vecs[i].slot});
            idle_inputs();
        end
        @(negedge clk);
        chk("table_no_flush", {31'h0, flush_o}, 32'h0);

        // Syscall: flush for exactly two cycles, second exception suppressed.
        @(negedge clk);
        syscall_at(32'hBFC00100);
        #1 chk("sys_code", excepttype_o, 32'h8);
        @(negedge clk);
        inst_valid_i = 1'b1; exc_flags_i = 8'h04;
        #1;
        chk("sys_flush1", {31'h0, flush_o}, 32'h1);
        chk("sys_newpc1", new_pc_o, 32'hBFC00380);
        chk("sys_suppress1", excepttype_o, 32'h0);
        @(negedge clk);
        #1;
        chk("sys_flush2", {31'h0, flush_o}, 32'h1);
        chk("sys_newpc2", new_pc_o, 32'hBFC00380);
        chk("sys_suppress2", excepttype_o, 32'h0);
        idle_inputs();
        @(negedge clk);
        #1 chk("sys_flush_end", {31'h0, flush_o}, 32'h0);

        // ERET with EPC written back in the same cycle.
        @(negedge clk);
        inst_valid_i = 1'b1; exc_flags_i = 8'h80; cp0_epc_i = 32'h100;
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'hBFC00400;
        #1 chk("eret_code", excepttype_o, 32'he);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("eret_flush", {31'h0, flush_o}, 32'h1);
        chk("eret_newpc", new_pc_o, 32'hBFC00400);
        repeat (2) @(negedge clk);
        #1 chk("eret_flush_end", {31'h0, flush_o}, 32'h0);

        // Stall holds off Ov; release lets it commit.
        @(negedge clk);
        stall = 1'b1; inst_valid_i = 1'b1; exc_flags_i = 8'h04;
        #1 chk("stall_code", excepttype_o, 32'h0);
        @(negedge clk);
        #1 chk("stall_no_flush", {31'h0, flush_o}, 32'h0);
        stall = 1'b0;
        #1 chk("unstall_code", excepttype_o, 32'hc);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("ov_flush", {31'h0, flush_o}, 32'h1);
        chk("ov_newpc", new_pc_o, 32'hBFC00380);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a flush.
        @(negedge clk);
        syscall_at(32'hBFC00100);
        @(negedge clk);
        #1 chk("rst_pre_flush", {31'h0, flush_o}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_flush", {31'h0, flush_o}, 32'h0);
        chk("rst_async_newpc", new_pc_o, 32'h0);
        chk("rst_async_code", excepttype_o, 32'h0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        syscall_at(32'hBFC00100);
        #1 chk("post_rst_code", excepttype_o, 32'h8);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("post_rst_flush1", {31'h0, flush_o}, 32'h1);
        chk("post_rst_newpc", new_pc_o, 32'hBFC00380);
        @(negedge clk);
        #1 chk("post_rst_flush2", {31'h0, flush_o}, 32'h1);
        @(negedge clk);
        #1 chk("post_rst_flush_end", {31'h0, flush_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
